l2_merge_rr: RTL and testbench

//  16:1 request merger for the L2 side of the multi-stream buffer. Up to 16 requesters

---
 rtl/l2_merge_rr.sv | 150 +++++++++++++++
 tb/tb_l2_merge_rr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/l2_merge_rr.sv
`default_nettype none
// ============================================================================
//  Module   : l2_merge_rr
//  Purpose  : 16:1 request merger with two pipelined round-robin levels.
//             Level 1 has four 4:1 round-robin muxes, one per group of four
//             requesters. Level 2 is one 4:1 round-robin mux across the
//             groups. Each level is registered, and the block emits one
//             4-bit requester ID per accepted handshake.
//  Revision : 1.0  initial release
// ============================================================================
module l2_merge_rr #(
    parameter int N_REQ = 16,
    parameter int GRP   = 4,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic [N_REQ-1:0] i_clreq_v,
    output logic [N_REQ-1:0] i_clreq_r,
    output logic             o_v,
    input  logic             o_r,
    output logic [ID_W-1:0]  o_clid_req
);

    // Group count and index widths. Only the 16 = 4 x 4 layout is supported.
    localparam int N_GRP = N_REQ / GRP;
    localparam int LID_W = 2;
    localparam int GID_W = 2;

    // ------------------------------------------------------------------
    // Round-robin pick over four candidates.
    // Result is {found, index}. The index is the first set bit at or after
    // ptr, wrapping modulo 4. The loop runs downward so that the smallest
    // offset is written last and therefore wins.
    // ------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res  = 3'b000;
        cand = 2'd0;
        for (int off = 3; off >= 0; off--) begin
            cand = ptr + off[1:0];
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Level-1 holding registers, one per group
    logic [N_GRP-1:0] s1_v_q,   s1_v_d;
    logic [LID_W-1:0] s1_id_q   [N_GRP];
    logic [LID_W-1:0] s1_id_d   [N_GRP];
    logic [LID_W-1:0] ptr1_q    [N_GRP];
    logic [LID_W-1:0] ptr1_d    [N_GRP];

    // Level-2 pointer and output register
    logic [GID_W-1:0] ptr2_q,   ptr2_d;
    logic             o_v_q,    o_v_d;
    logic [ID_W-1:0]  o_clid_q, o_clid_d;

    // Combinational arbitration signals
    logic             w_out_load;
    logic [2:0]       w_l2_pick;
    logic             w_l2_gnt;
    logic [GID_W-1:0] w_l2_grp;
    logic [N_GRP-1:0] w_l2_take;
    logic [N_GRP-1:0] w_s1_load;
    logic [2:0]       w_l1_pick [N_GRP];
    logic [N_REQ-1:0] w_gnt;

    // Level-2 arbitration. The output register is free when it is empty or
    // is being drained this cycle, so o_r only reaches the ready side.
    always_comb begin
        w_out_load = !o_v_q || o_r;
        w_l2_pick  = rr_pick(s1_v_q, ptr2_q);
        w_l2_gnt   = w_out_load && w_l2_pick[2];
        w_l2_grp   = w_l2_pick[1:0];
        w_l2_take  = w_l2_gnt ? (4'b0001 << w_l2_grp) : 4'b0000;
    end

    // Level-1 arbitration and next-state for all pipeline registers
    always_comb begin
        s1_v_d   = s1_v_q;
        s1_id_d  = s1_id_q;
        ptr1_d   = ptr1_q;
        ptr2_d   = ptr2_q;
        o_v_d    = o_v_q;
        o_clid_d = o_clid_q;
        w_gnt    = '0;
        w_s1_load = '0;

        for (int g = 0; g < N_GRP; g++) begin
            // A group register can refill in the same cycle that level 2
            // drains it, which keeps sustained throughput at one per cycle.
            w_s1_load[g] = !s1_v_q[g] || w_l2_take[g];
            w_l1_pick[g] = rr_pick(i_clreq_v[g*GRP +: GRP], ptr1_q[g]);

            if (w_s1_load[g] && w_l1_pick[g][2]) begin
                w_gnt[g*GRP +: GRP] = 4'b0001 << w_l1_pick[g][1:0];
                s1_v_d[g]           = 1'b1;
                s1_id_d[g]          = w_l1_pick[g][1:0];
                ptr1_d[g]           = w_l1_pick[g][1:0] + 2'd1;
            end else if (w_l2_take[g]) begin
                s1_v_d[g] = 1'b0;
            end
        end

        if (w_l2_gnt) begin
            o_v_d    = 1'b1;
            o_clid_d = {w_l2_grp, s1_id_q[w_l2_grp]};
            ptr2_d   = w_l2_grp + 2'd1;
        end else if (o_r) begin
            // Output drained with nothing behind it. The ID keeps its last value.
            o_v_d = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_v_q   <= '0;
            ptr2_q   <= '0;
            o_v_q    <= 1'b0;
            o_clid_q <= '0;
            for (int g = 0; g < N_GRP; g++) begin
                s1_id_q[g] <= '0;
                ptr1_q[g]  <= '0;
            end
        end else begin
            s1_v_q   <= s1_v_d;
            s1_id_q  <= s1_id_d;
            ptr1_q   <= ptr1_d;
            ptr2_q   <= ptr2_d;
            o_v_q    <= o_v_d;
            o_clid_q <= o_clid_d;
        end
    end

    // Grants are suppressed while reset is held. The state is already
    // cleared then, so the level-1 muxes would otherwise report ready.
    always_comb begin
        i_clreq_r  = reset ? w_gnt : '0;
        o_v        = o_v_q;
        o_clid_req = o_clid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_merge_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_merge_rr
//  Purpose  : Directed self-checking bench for l2_merge_rr
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_merge_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] clreq_v;
    logic [15:0] clreq_r;
    logic        out_v;
    logic        out_r;
    logic [3:0]  clid;

    int n_checks = 0;
    int n_errors = 0;
    int k;

    always #5 clk = ~clk;

    l2_merge_rr u_dut (
        .clk        (clk),
        .reset      (reset),
        .i_clreq_v  (clreq_v),
        .i_clreq_r  (clreq_r),
        .o_v        (out_v),
        .o_r        (out_r),
        .o_clid_req (clid)
    );

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One directed cycle: drive the valids, then sample at the falling edge
    task automatic cyc(input string tag, input logic [15:0] vin, input logic [15:0] exp_r,
                       input logic exp_ov, input logic [3:0] exp_id);
        clreq_v = vin;
        @(negedge clk);
        check({tag, ".ready"}, 32'(clreq_r), 32'(exp_r));
        check({tag, ".o_v"},   32'(out_v),   32'(exp_ov));
        if (exp_ov) check({tag, ".id"}, 32'(clid), 32'(exp_id));
        next_cycle();
    endtask

    // Hold reset with every requester valid and confirm that all outputs stay quiet
    task automatic do_reset();
        reset   = 1'b0;
        clreq_v = 16'hFFFF;
        out_r   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.o_v",   32'(out_v),   32'd0);
            check("rst.id",    32'(clid),    32'd0);
            check("rst.ready", 32'(clreq_r), 32'd0);
        end
        next_cycle();
        reset   = 1'b1;
        clreq_v = 16'h0000;
    endtask

    // Steady-state order under full load: the group rotates fastest,
    // and the local index advances once per sweep of the four groups
    function automatic logic [3:0] full_load_id(input int n);
        return 4'((n % 4) * 4 + ((n / 4) % 4));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then idle
        do_reset();
        for (int c = 0; c < 3; c++) cyc("idle", 16'h0000, 16'h0000, 1'b0, 4'd0);

        // 2: one-hot walk, IDs appear two cycles later
        for (int c = 0; c < 20; c++) begin
            clreq_v = (c < 16) ? (16'd1 << c) : 16'h0000;
            @(negedge clk);
            check("walk.ready", 32'(clreq_r), 32'(clreq_v));
            check("walk.o_v",   32'(out_v),   32'((c >= 2) && (c < 18)));
            if (out_v) check("walk.id", 32'(clid), 32'(c - 2));
            next_cycle();
        end

        // 3: two groups in the same cycle
        do_reset();
        cyc("dg0", 16'h0022, 16'h0022, 1'b0, 4'd0);
        cyc("dg1", 16'h0000, 16'h0000, 1'b0, 4'd0);
        cyc("dg2", 16'h0000, 16'h0000, 1'b1, 4'd1);
        cyc("dg3", 16'h0000, 16'h0000, 1'b1, 4'd5);
        cyc("dg4", 16'h0000, 16'h0000, 1'b0, 4'd0);

        // 4: two requests in the same group, the lower one wins from pointer 0
        do_reset();
        cyc("sg0", 16'h0006, 16'h0002, 1'b0, 4'd0);
        cyc("sg1", 16'h0000, 16'h0000, 1'b0, 4'd0);
        cyc("sg2", 16'h0000, 16'h0000, 1'b1, 4'd1);
        cyc("sg3", 16'h0000, 16'h0000, 1'b0, 4'd0);
        cyc("sg4", 16'h0000, 16'h0000, 1'b0, 4'd0);

        // 5: requesters 1,2,5,6 each hold valid until accepted.
        // Group 1 is full in the second cycle, so requester 6 waits one cycle.
        do_reset();
        cyc("hd0", 16'h0066, 16'h0022, 1'b0, 4'd0);
        cyc("hd1", 16'h0044, 16'h0004, 1'b0, 4'd0);
        cyc("hd2", 16'h0040, 16'h0040, 1'b1, 4'd1);
        cyc("hd3", 16'h0000, 16'h0000, 1'b1, 4'd5);
        cyc("hd4", 16'h0000, 16'h0000, 1'b1, 4'd2);
        cyc("hd5", 16'h0000, 16'h0000, 1'b1, 4'd6);
        cyc("hd6", 16'h0000, 16'h0000, 1'b0, 4'd0);

        // 6: full load, then backpressure, then resume
        do_reset();
        cyc("fl0", 16'hFFFF, 16'h1111, 1'b0, 4'd0);
        cyc("fl1", 16'hFFFF, 16'h0002, 1'b0, 4'd0);
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("full.o_v", 32'(out_v), 32'd1);
            check("full.id",  32'(clid),  32'(full_load_id(k)));
            k++;
            next_cycle();
        end
        out_r = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp.o_v",   32'(out_v),   32'd1);
            check("bp.id",    32'(clid),    32'(full_load_id(k)));
            check("bp.ready", 32'(clreq_r), 32'd0);
            next_cycle();
        end
        out_r = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("resume.o_v", 32'(out_v), 32'd1);
            check("resume.id",  32'(clid),  32'(full_load_id(k)));
            k++;
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
